// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed 16/8 restoring divider with a one-entry pending request buffer
module div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_vld,
    input  logic [15:0] in0_data,
    input  logic [7:0]  in1_data,
    output logic        div_busy,
    output logic        div_full,
    output logic        out_vld,
    output logic [15:0] out_quot,
    output logic [7:0]  out_rem,
    output logic        out_div0
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] buf_a;
    logic [7:0]  buf_b;
    logic [15:0] q_r;
    logic [7:0]  rem_r;
    logic [7:0]  b_mag;
    logic        neg_q;
    logic        neg_r;

    logic        ld_en;
    logic        buf_wr;
    logic [15:0] ld_a;
    logic [7:0]  ld_b;
    logic [15:0] ld_a_mag;
    logic [7:0]  ld_b_mag;
    logic        ld_div0;

    logic [8:0]  shifted;
    logic        fits;
    logic [7:0]  diff;
    logic [7:0]  rem_next;
    logic [15:0] q_next;

    // Engine load source: direct input in IDLE; in DONE the buffer has priority,
    // and a new request arriving alongside it takes the buffer slot instead.
    always_comb begin
        ld_en  = 1'b0;
        buf_wr = 1'b0;
        ld_a   = in0_data;
        ld_b   = in1_data;
        case (state)
            IDLE: ld_en = div_vld;
            CALC: buf_wr = div_vld & ~div_full;
            DONE: begin
                ld_en = div_full | div_vld;
                if (div_full) begin
                    ld_a   = buf_a;
                    ld_b   = buf_b;
                    buf_wr = div_vld;
                end
            end
            default: ;
        endcase
    end

    // Magnitudes fit unsigned in the native widths, including -32768 and -128.
    assign ld_a_mag = ld_a[15] ? (16'd0 - ld_a) : ld_a;
    assign ld_b_mag = ld_b[7]  ? (8'd0 - ld_b)  : ld_b;
    assign ld_div0  = (ld_b == 8'd0);

    // Partial remainder stays below the divisor magnitude (<= 128), so the
    // low byte of the trial difference is exact whenever the trial fits.
    assign shifted  = {rem_r, q_r[15]};
    assign fits     = (shifted >= {1'b0, b_mag});
    assign diff     = shifted[7:0] - b_mag;
    assign rem_next = fits ? diff : shifted[7:0];
    assign q_next   = {q_r[14:0], fits};

    assign div_busy = (state != IDLE) | div_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            buf_a    <= 16'd0;
            buf_b    <= 8'd0;
            div_full <= 1'b0;
            q_r      <= 16'd0;
            rem_r    <= 8'd0;
            b_mag    <= 8'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            out_vld  <= 1'b0;
            out_quot <= 16'd0;
            out_rem  <= 8'd0;
            out_div0 <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            if (buf_wr) begin
                buf_a    <= in0_data;
                buf_b    <= in1_data;
                div_full <= 1'b1;
            end else if (state == DONE) begin
                div_full <= 1'b0;
            end

            if (ld_en) begin
                q_r   <= ld_a_mag;
                rem_r <= 8'd0;
                b_mag <= ld_b_mag;
                neg_q <= ld_a[15] ^ ld_b[7];
                neg_r <= ld_a[15];
                cnt   <= 4'd0;
                if (ld_div0) begin
                    state    <= DONE;
                    out_vld  <= 1'b1;
                    out_quot <= 16'd0;
                    out_rem  <= ld_a[7:0];
                    out_div0 <= 1'b1;
                end else begin
                    state <= CALC;
                end
            end else begin
                case (state)
                    CALC: begin
                        q_r   <= q_next;
                        rem_r <= rem_next;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state    <= DONE;
                            out_vld  <= 1'b1;
                            out_quot <= neg_q ? (16'd0 - q_next) : q_next;
                            out_rem  <= neg_r ? (8'd0 - rem_next) : rem_next;
                            out_div0 <= 1'b0;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
